// File: rtl/imem_load_pkg.sv
// Shared types and helpers for the boot-time instruction memory loader.
package imem_load_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } load_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Big-endian packing: earlier bytes end up in the upper lanes.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  byte_in);
        return {word[23:0], byte_in};
    endfunction

endpackage

// File: rtl/imem_load_ctrl_packer.sv
// Byte-to-word packer: shift-left-by-8 register plus a byte counter.
// word_valid/word_data present the completed word in the cycle of the last byte.
module imem_byte_packer
    import imem_load_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [31:0]           word_data,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]           shift_r;
    logic [BYTE_CNT_W-1:0] cnt_r;

    // Shift register and byte counter; clear takes priority over an incoming byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 32'd0;
            cnt_r   <= '0;
        end else if (clear) begin
            shift_r <= 32'd0;
            cnt_r   <= '0;
        end else if (byte_valid) begin
            shift_r <= shift_in_byte(shift_r, byte_data);
            cnt_r   <= cnt_r + BYTE_CNT_W'(1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Completed word is the current shift contents plus the byte arriving now.
    always_comb begin
        word_data  = shift_in_byte(shift_r, byte_data);
        word_valid = 1'b0;
        if (byte_valid && !clear && (cnt_r == LAST_BYTE)) begin
            word_valid = 1'b1;
        end else begin
            word_valid = 1'b0;
        end
    end

    assign byte_cnt = cnt_r;

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot loader: packs UART bytes into words, writes them to imem and holds the
// CPU in reset until DEPTH_WORDS words have been written.
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int DEPTH_WORDS    = 64,
    parameter int ADDR_W         = $clog2(DEPTH_WORDS),
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              err_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    load_state_t           state_r;
    logic [ADDR_W-1:0]     word_idx_r;
    logic [IDLE_W-1:0]     idle_cnt_r;
    logic                  imem_we_r;
    logic [ADDR_W-1:0]     imem_addr_r;
    logic [31:0]           imem_wdata_r;
    logic                  cpu_rst_n_r;
    logic                  load_done_r;
    logic                  err_timeout_r;

    logic                  byte_take_s;
    logic                  partial_s;
    logic                  timeout_hit_s;
    logic                  packer_clear_s;
    logic                  word_valid_s;
    logic [31:0]           word_data_s;
    logic [BYTE_CNT_W-1:0] byte_cnt_s;

    // Byte acceptance and timeout detection; reload drops a coincident byte.
    always_comb begin
        byte_take_s   = 1'b0;
        partial_s     = 1'b0;
        timeout_hit_s = 1'b0;
        if (rx_valid && !reload && (state_r != DONE)) begin
            byte_take_s = 1'b1;
        end else begin
            byte_take_s = 1'b0;
        end
        if ((state_r == RECV) && (byte_cnt_s != '0)) begin
            partial_s = 1'b1;
        end else begin
            partial_s = 1'b0;
        end
        if (partial_s && !rx_valid && (idle_cnt_r == IDLE_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    assign packer_clear_s = reload | timeout_hit_s;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear_s),
        .byte_valid (byte_take_s),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word_data  (word_data_s),
        .byte_cnt   (byte_cnt_s)
    );

    // Idle gap counter: runs only while a partial word is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (reload || timeout_hit_s) begin
            idle_cnt_r <= '0;
        end else if (partial_s && !rx_valid) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end else begin
            idle_cnt_r <= '0;
        end
    end

    // Load FSM with registered imem port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            word_idx_r    <= '0;
            imem_we_r     <= 1'b0;
            imem_addr_r   <= '0;
            imem_wdata_r  <= 32'd0;
            cpu_rst_n_r   <= 1'b0;
            load_done_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else if (reload) begin
            state_r       <= IDLE;
            word_idx_r    <= '0;
            imem_we_r     <= 1'b0;
            imem_addr_r   <= '0;
            imem_wdata_r  <= 32'd0;
            cpu_rst_n_r   <= 1'b0;
            load_done_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    imem_we_r <= 1'b0;
                    if (rx_valid) begin
                        state_r <= RECV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    imem_we_r <= 1'b0;
                    if (timeout_hit_s) begin
                        state_r       <= IDLE;
                        err_timeout_r <= 1'b1;
                    end else if (word_valid_s) begin
                        state_r      <= WRITE;
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= word_idx_r;
                        imem_wdata_r <= word_data_s;
                    end else begin
                        state_r <= RECV;
                    end
                end
                WRITE: begin
                    imem_we_r <= 1'b0;
                    // The index never wraps: the last slot hands over to DONE.
                    if (word_idx_r == LAST_IDX) begin
                        state_r     <= DONE;
                        load_done_r <= 1'b1;
                        cpu_rst_n_r <= 1'b1;
                    end else begin
                        state_r    <= RECV;
                        word_idx_r <= word_idx_r + ADDR_W'(1);
                    end
                end
                DONE: begin
                    imem_we_r   <= 1'b0;
                    load_done_r <= 1'b1;
                    cpu_rst_n_r <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    imem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_we     = imem_we_r;
    assign imem_addr   = imem_addr_r;
    assign imem_wdata  = imem_wdata_r;
    assign cpu_rst_n   = cpu_rst_n_r;
    assign load_done   = load_done_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a 64-word instance and a 2-word instance
// share the byte stream.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;

    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        load_done;
    logic        err_timeout;

    logic        s_imem_we;
    logic [0:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_cpu_rst_n;
    logic        s_load_done;
    logic        s_err_timeout;

    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          s_wr_cnt = 0;
    int          base_cnt;
    logic [5:0]  last_addr = 6'd0;
    logic [31:0] wr_mem [64];

    imem_load_ctrl #(.DEPTH_WORDS(64), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .load_done(load_done),
        .err_timeout(err_timeout)
    );

    imem_load_ctrl #(.DEPTH_WORDS(2), .TIMEOUT_CYCLES(1000)) dut_s (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .reload(reload), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .cpu_rst_n(s_cpu_rst_n), .load_done(s_load_done),
        .err_timeout(s_err_timeout)
    );

    always #5 clk = ~clk;

    // Write log, sampled on the inactive edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_cnt = wr_cnt + 1;
            wr_mem[imem_addr] = imem_wdata;
            last_addr = imem_addr;
        end
        if (s_imem_we) begin
            s_wr_cnt = s_wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Leaves the caller 1 ns after the edge that sampled the fourth byte.
    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (k < 3) tick();
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        case (i)
            0:       return 32'h00A00293;
            1:       return 32'h00500313;
            2:       return 32'h006283B3;
            3:       return 32'h40628433;
            4:       return 32'h405244B3;
            default: return 32'h00000013;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) wr_mem[i] = 32'd0;
        rst_n = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'd0;
        #3;
        check("rst_we",    32'(imem_we), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu",   32'(cpu_rst_n), 32'd0);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
        check("rst_s_err", 32'(s_err_timeout), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single word on the 2-word instance, then the full 64-word image.
        send_word(exp_word(0));
        check("s_we_lat",  32'(s_imem_we), 32'd1);
        check("s_addr0",   32'(s_imem_addr), 32'd0);
        check("s_data0",   s_imem_wdata, 32'h00A00293);
        check("we_lat",    32'(imem_we), 32'd1);
        tick();
        check("s_we_pulse", 32'(s_imem_we), 32'd0);
        check("s_done_lo",  32'(s_load_done), 32'd0);
        check("s_wr_cnt1",  32'(s_wr_cnt), 32'd1);
        for (int i = 1; i < 64; i++) begin
            send_word(exp_word(i));
            if (i == 63) begin
                check("last_we",   32'(imem_we), 32'd1);
                check("last_addr", 32'(imem_addr), 32'd63);
                check("done_early", 32'(load_done), 32'd0);
                check("cpu_early",  32'(cpu_rst_n), 32'd0);
            end
            tick();
            if (i == 1) begin
                check("s_done",    32'(s_load_done), 32'd1);
                check("s_cpu_rst", 32'(s_cpu_rst_n), 32'd1);
            end
        end
        check("done",      32'(load_done), 32'd1);
        check("cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("we_after",  32'(imem_we), 32'd0);
        check("wr_cnt64",  32'(wr_cnt), 32'd64);
        check("word4",     wr_mem[4], 32'h405244B3);
        for (int i = 0; i < 64; i++) check($sformatf("mem%0d", i), wr_mem[i], exp_word(i));
        check("s_wr_cnt2", 32'(s_wr_cnt), 32'd2);

        // Extra bytes after DONE are ignored.
        send_word(32'hDEADBEEF);
        tick(); tick();
        check("extra_cnt",  32'(wr_cnt), 32'd64);
        check("extra_done", 32'(load_done), 32'd1);

        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("rl_done", 32'(load_done), 32'd0);
        check("rl_cpu",  32'(cpu_rst_n), 32'd0);
        base_cnt = wr_cnt;

        // Timeout after a two-byte partial word.
        send_byte(8'h00); tick();
        send_byte(8'hA0);
        repeat (999) tick();
        check("to_early", 32'(err_timeout), 32'd0);
        tick();
        check("to_err",   32'(err_timeout), 32'd1);
        check("to_nowr",  32'(wr_cnt - base_cnt), 32'd0);
        send_word(32'h00528333);
        check("to_we",    32'(imem_we), 32'd1);
        check("to_addr",  32'(imem_addr), 32'd0);
        check("to_data",  imem_wdata, 32'h00528333);
        tick();

        // Reload mid-word at address 10 with a coincident byte.
        for (int i = 1; i < 10; i++) begin
            send_word(32'h10000000 + i);
            tick();
        end
        check("pre_rl_addr", 32'(last_addr), 32'd9);
        send_byte(8'hAA); tick();
        send_byte(8'hBB); tick();
        rx_data = 8'hCC; rx_valid = 1'b1; reload = 1'b1;
        tick();
        rx_valid = 1'b0; reload = 1'b0;
        check("rl2_done", 32'(load_done), 32'd0);
        check("rl2_cpu",  32'(cpu_rst_n), 32'd0);
        check("rl2_err",  32'(err_timeout), 32'd0);
        tick();
        send_word(32'h11223344);
        check("rl2_we",   32'(imem_we), 32'd1);
        check("rl2_addr", 32'(imem_addr), 32'd0);
        check("rl2_data", imem_wdata, 32'h11223344);
        tick();

        // Asynchronous reset pulse in the middle of a WRITE cycle.
        send_word(32'h55667788);
        check("ar_pre_addr", 32'(imem_addr), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_we",    32'(imem_we), 32'd0);
        check("ar_addr",  32'(imem_addr), 32'd0);
        check("ar_wdata", imem_wdata, 32'd0);
        check("ar_cpu",   32'(cpu_rst_n), 32'd0);
        check("ar_done",  32'(load_done), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("ar_post_we", 32'(imem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
